// File: rtl/down_count_pkg.sv
// -----------------------------------------------------------------------------
// down_count_pkg
// Shared definitions for the down-counting interval timer.
//   - state_e       : FSM states IDLE / COUNT / DONE
//   - ENC_*         : state encodings, kept separate so the encoding is visible
//                     and can be referenced by anything that decodes state bits
//   - DEFAULT_WIDTH : default counter width used by the timer and its core
// Optional feature macro (consumed by down_count_timer): DOWN_COUNT_AUTO_RELOAD_EN
// -----------------------------------------------------------------------------
package down_count_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ENC_IDLE  = 2'b00;
  localparam logic [1:0] ENC_COUNT = 2'b01;
  localparam logic [1:0] ENC_DONE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_COUNT = ENC_COUNT,
    ST_DONE  = ENC_DONE
  } state_e;

endpackage : down_count_pkg

// File: rtl/down_count_core.sv
// -----------------------------------------------------------------------------
// down_count_core
// WIDTH-bit count register with load, hold and saturating decrement, plus
// zero / one detection for the controlling FSM.
// Ports:
//   clk        in   1      clock, all updates on posedge
//   reset      in   1      synchronous active-low clear
//   load_i     in   1      load load_val_i (has priority over decrement)
//   load_val_i in   WIDTH  value to load
//   dec_i      in   1      decrement by one; count never goes below zero
//   q_o        out  WIDTH  registered count
//   zero_o     out  1      q_o == 0
//   one_o      out  1      q_o == 1
// Neither load_i nor dec_i asserted means the count holds.
// -----------------------------------------------------------------------------
module down_count_core
  import down_count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o,
  output logic             zero_o,
  output logic             one_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      // Saturate at zero: a decrement request at zero is dropped, never wraps.
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o    = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_ONE);

endmodule : down_count_core

// File: rtl/down_count_timer.sv
// -----------------------------------------------------------------------------
// down_count_timer
// Synchronous loadable down-counter / interval timer. Counts from a loaded
// value to zero, pulses tc in the cycle q first reads zero and done the cycle
// after. All outputs are registered; there is no combinational input->output
// path.
// Ports:
//   clk       in   1      clock, all state changes on posedge
//   reset     in   1      synchronous active-low reset, overrides all inputs
//   start     in   1      start request, accepted only in IDLE
//   load_val  in   WIDTH  start value, captured when start is accepted
//   hold      in   1      freezes q / state / busy while counting
//   q         out  WIDTH  current count
//   busy      out  1      high from start acceptance until done is asserted
//   tc        out  1      terminal-count pulse
//   done      out  1      one-cycle completion pulse, the cycle after tc
// Optional feature macro: DOWN_COUNT_AUTO_RELOAD_EN
//   When defined the timer reloads the captured start value after each
//   terminal count (periodic tc every L+1 non-held cycles) and a start while
//   counting terminates the run through DONE. When undefined the timer is
//   one-shot and start while busy is ignored.
// -----------------------------------------------------------------------------
module down_count_timer
  import down_count_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   tc_q, tc_d;
  logic   done_q, done_d;

  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_dec;
  logic [WIDTH-1:0] core_q;
  logic             q_zero;
  logic             q_one;

`ifdef DOWN_COUNT_AUTO_RELOAD_EN
  // Start value kept for periodic reloads; only needed when reloading.
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (core_load),
    .load_val_i (core_load_val),
    .dec_i      (core_dec),
    .q_o        (core_q),
    .zero_o     (q_zero),
    .one_o      (q_one)
  );

  // Next-state and registered-output logic. tc and done are pulses, so they
  // default to 0 and are raised only on the transitions that produce them.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    tc_d          = 1'b0;
    done_d        = 1'b0;
    core_load     = 1'b0;
    core_load_val = load_val;
    core_dec      = 1'b0;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
    reload_d      = reload_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          core_load = 1'b1;
          busy_d    = 1'b1;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
          reload_d  = load_val;
          // A zero start value still runs periodically: tc every cycle.
          state_d   = ST_COUNT;
          tc_d      = (load_val == '0);
`else
          if (load_val == '0) begin
            state_d = ST_DONE;
            tc_d    = 1'b1;
          end else begin
            state_d = ST_COUNT;
          end
`endif
        end
      end

      ST_COUNT: begin
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
        if (start) begin
          // Stop request: finish through DONE with q left where it is.
          state_d = ST_DONE;
        end else if (!hold) begin
          if (q_zero) begin
            core_load     = 1'b1;
            core_load_val = reload_q;
            tc_d          = (reload_q == '0);
          end else begin
            core_dec = 1'b1;
            tc_d     = q_one;
          end
        end
`else
        if (!hold) begin
          core_dec = 1'b1;
          if (q_one) begin
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else if (q_zero) begin
            // Not reachable from IDLE (zero loads go straight to DONE);
            // guards against ever parking in COUNT at zero.
            state_d = ST_DONE;
          end
        end
`endif
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q    = core_q;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule : down_count_timer
